// File: rtl/data_mem_arb_pkg.sv
// Shared types and default widths for the data memory arbiter.
package data_mem_arb_pkg;

  typedef enum logic {IDLE, ACCESS} arb_state_t;
  typedef enum logic {OWN_A, OWN_B} arb_owner_t;

  localparam int unsigned DEF_ADDR_W    = 4;
  localparam int unsigned DEF_DATA_W    = 8;
  localparam int unsigned DEF_MAX_BURST = 4;

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way picker: lock/burst rules first, then fixed priority or round-robin.
module rr_arb2
  import data_mem_arb_pkg::*;
(
  input  logic       req_a,
  input  logic       req_b,
  input  arb_owner_t last,
  input  logic       fixed_prio,
  input  logic       lock,
  input  arb_owner_t lock_owner,
  input  logic       burst_ok,
  output arb_owner_t winner,
  output logic       valid
);

  logic owner_req;
  logic other_req;

  always_comb begin
    owner_req = (lock_owner == OWN_A) ? req_a : req_b;
    other_req = (lock_owner == OWN_A) ? req_b : req_a;
    valid     = req_a | req_b;
    winner    = OWN_A;
    // An exhausted burst yields to a waiting port even under fixed priority.
    if (lock && owner_req && (burst_ok || !other_req))
      winner = lock_owner;
    else if (lock && owner_req)
      winner = (lock_owner == OWN_A) ? OWN_B : OWN_A;
    else if (req_a && req_b)
      winner = (fixed_prio || last == OWN_B) ? OWN_A : OWN_B;
    else if (req_b)
      winner = OWN_B;
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Two-port arbiter for the single-port data memory: one registered access per cycle,
// read data returned on the cycle after the grant.
module data_mem_arbiter
  import data_mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = DEF_ADDR_W,
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter bit          FIXED_PRIO = 1'b0,
  parameter int unsigned MAX_BURST  = DEF_MAX_BURST
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_a_req,
  input  logic              i_a_we,
  input  logic              i_a_lock,
  input  logic [ADDR_W-1:0] i_a_addr,
  input  logic [DATA_W-1:0] i_a_wdata,
  output logic              o_a_gnt,
  output logic              o_a_done,
  output logic [DATA_W-1:0] o_a_rdata,
  input  logic              i_b_req,
  input  logic              i_b_we,
  input  logic              i_b_lock,
  input  logic [ADDR_W-1:0] i_b_addr,
  input  logic [DATA_W-1:0] i_b_wdata,
  output logic              o_b_gnt,
  output logic              o_b_done,
  output logic [DATA_W-1:0] o_b_rdata,
  output logic              o_mem_enable,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic              o_busy
);

  localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

  arb_state_t       state;
  arb_owner_t       owner;
  arb_owner_t       last;
  arb_owner_t       winner;
  logic             lock_q;
  logic [CNT_W-1:0] burst_cnt;
  logic             grant_any;
  logic             locked;
  logic             burst_ok;
  logic             relock;

  assign locked   = (state == ACCESS) && lock_q;
  assign burst_ok = burst_cnt < CNT_W'(MAX_BURST);
  assign relock   = locked && (winner == owner);
  assign o_busy   = (state != IDLE);

  rr_arb2 u_arb (
    .req_a      (i_a_req),
    .req_b      (i_b_req),
    .last       (last),
    .fixed_prio (FIXED_PRIO),
    .lock       (locked),
    .lock_owner (owner),
    .burst_ok   (burst_ok),
    .winner     (winner),
    .valid      (grant_any)
  );

  // The memory pins double as the latched request: they are only valid in ACCESS.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      owner        <= OWN_A;
      last         <= OWN_B;
      lock_q       <= 1'b0;
      burst_cnt    <= '0;
      o_a_gnt      <= 1'b0;
      o_b_gnt      <= 1'b0;
      o_a_done     <= 1'b0;
      o_b_done     <= 1'b0;
      o_a_rdata    <= '0;
      o_b_rdata    <= '0;
      o_mem_enable <= 1'b0;
      o_mem_we     <= 1'b0;
      o_mem_addr   <= '0;
      o_mem_wdata  <= '0;
    end else begin
      o_a_done <= o_a_gnt;
      o_b_done <= o_b_gnt;
      if (o_a_gnt && !o_mem_we) o_a_rdata <= i_mem_rdata;
      if (o_b_gnt && !o_mem_we) o_b_rdata <= i_mem_rdata;

      if (grant_any) begin
        state        <= ACCESS;
        owner        <= winner;
        last         <= winner;
        o_mem_enable <= 1'b1;
        o_a_gnt      <= (winner == OWN_A);
        o_b_gnt      <= (winner == OWN_B);
        if (winner == OWN_A) begin
          o_mem_we    <= i_a_we;
          o_mem_addr  <= i_a_addr;
          o_mem_wdata <= i_a_wdata;
          lock_q      <= i_a_lock;
        end else begin
          o_mem_we    <= i_b_we;
          o_mem_addr  <= i_b_addr;
          o_mem_wdata <= i_b_wdata;
          lock_q      <= i_b_lock;
        end
        // Saturate when the owner keeps the bus only because nobody else is waiting.
        if (relock)
          burst_cnt <= burst_ok ? burst_cnt + CNT_W'(1) : burst_cnt;
        else
          burst_cnt <= '0;
      end else begin
        state        <= IDLE;
        lock_q       <= 1'b0;
        burst_cnt    <= '0;
        o_a_gnt      <= 1'b0;
        o_b_gnt      <= 1'b0;
        o_mem_enable <= 1'b0;
        o_mem_we     <= 1'b0;
        o_mem_addr   <= '0;
        o_mem_wdata  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed scoreboard bench: round-robin instance with memory model, plus a fixed-priority instance.
module tb_data_mem_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       a_req, a_we, a_lock, b_req, b_we, b_lock;
  logic [3:0] a_addr, b_addr;
  logic [7:0] a_wdata, b_wdata;

  logic       a_gnt, a_done, b_gnt, b_done, mem_en, mem_we, busy;
  logic [7:0] a_rdata, b_rdata, mem_wdata, mem_rdata;
  logic [3:0] mem_addr;

  logic       a_gnt1, a_done1, b_gnt1, b_done1, mem_en1, mem_we1, busy1;
  logic [7:0] a_rdata1, b_rdata1, mem_wdata1;
  logic [3:0] mem_addr1;

  logic [7:0] tb_mem [16];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_en && mem_we) tb_mem[mem_addr] <= mem_wdata;
  assign mem_rdata = tb_mem[mem_addr];

  data_mem_arbiter #(.ADDR_W(4), .DATA_W(8), .FIXED_PRIO(1'b0), .MAX_BURST(4)) dut (
    .clk(clk), .rst(rst),
    .i_a_req(a_req), .i_a_we(a_we), .i_a_lock(a_lock), .i_a_addr(a_addr), .i_a_wdata(a_wdata),
    .o_a_gnt(a_gnt), .o_a_done(a_done), .o_a_rdata(a_rdata),
    .i_b_req(b_req), .i_b_we(b_we), .i_b_lock(b_lock), .i_b_addr(b_addr), .i_b_wdata(b_wdata),
    .o_b_gnt(b_gnt), .o_b_done(b_done), .o_b_rdata(b_rdata),
    .o_mem_enable(mem_en), .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
    .i_mem_rdata(mem_rdata), .o_busy(busy)
  );

  data_mem_arbiter #(.ADDR_W(4), .DATA_W(8), .FIXED_PRIO(1'b1), .MAX_BURST(4)) dut_fp (
    .clk(clk), .rst(rst),
    .i_a_req(a_req), .i_a_we(a_we), .i_a_lock(a_lock), .i_a_addr(a_addr), .i_a_wdata(a_wdata),
    .o_a_gnt(a_gnt1), .o_a_done(a_done1), .o_a_rdata(a_rdata1),
    .i_b_req(b_req), .i_b_we(b_we), .i_b_lock(b_lock), .i_b_addr(b_addr), .i_b_wdata(b_wdata),
    .o_b_gnt(b_gnt1), .o_b_done(b_done1), .o_b_rdata(b_rdata1),
    .o_mem_enable(mem_en1), .o_mem_we(mem_we1), .o_mem_addr(mem_addr1), .o_mem_wdata(mem_wdata1),
    .i_mem_rdata(8'h00), .o_busy(busy1)
  );

  // g0/g1: expected grant for each instance (0 none, 1 A, 2 B)
  typedef struct {
    logic [1:0] g0;
    logic [1:0] g1;
    logic       we;
    logic [3:0] addr;
    logic       rd;
    logic [7:0] rdata;
  } exp_t;

  exp_t sb[$];
  exp_t prev;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk); #1;
    if (sb.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    chk("a_gnt", {31'd0, a_gnt}, {31'd0, e.g0 == 2'd1});
    chk("b_gnt", {31'd0, b_gnt}, {31'd0, e.g0 == 2'd2});
    chk("fp_a_gnt", {31'd0, a_gnt1}, {31'd0, e.g1 == 2'd1});
    chk("fp_b_gnt", {31'd0, b_gnt1}, {31'd0, e.g1 == 2'd2});
    chk("busy", {31'd0, busy}, {31'd0, e.g0 != 2'd0});
    chk("a_done", {31'd0, a_done}, {31'd0, prev.g0 == 2'd1});
    chk("b_done", {31'd0, b_done}, {31'd0, prev.g0 == 2'd2});
    if (e.g0 != 2'd0) begin
      chk("mem_en", {31'd0, mem_en}, 32'd1);
      chk("mem_we", {31'd0, mem_we}, {31'd0, e.we});
      chk("mem_addr", {28'd0, mem_addr}, {28'd0, e.addr});
    end else begin
      chk("idle_mem_en", {31'd0, mem_en}, 32'd0);
      chk("idle_mem_addr", {28'd0, mem_addr}, 32'd0);
    end
    if (prev.rd)
      chk("rdata", {24'd0, (prev.g0 == 2'd1) ? a_rdata : b_rdata}, {24'd0, prev.rdata});
    prev = e;
  endtask

  task automatic cyc(input logic ar, input logic aw, input logic al, input logic [3:0] aad,
                     input logic [7:0] ad, input logic br, input logic bw, input logic [3:0] bad,
                     input logic [7:0] bd, input logic [1:0] g0, input logic [1:0] g1,
                     input logic [7:0] rdv);
    exp_t e;
    a_req = ar; a_we = aw; a_lock = al; a_addr = aad; a_wdata = ad;
    b_req = br; b_we = bw; b_lock = 1'b0; b_addr = bad; b_wdata = bd;
    e.g0    = g0;
    e.g1    = g1;
    e.we    = (g0 == 2'd1) ? aw : bw;
    e.addr  = (g0 == 2'd1) ? aad : bad;
    e.rd    = (g0 != 2'd0) && !e.we;
    e.rdata = rdv;
    sb.push_back(e);
    tick();
  endtask

  task automatic idle();
    cyc(0, 0, 0, 4'h0, 8'h00, 0, 0, 4'h0, 8'h00, 2'd0, 2'd0, 8'h00);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_a_gnt"}, {31'd0, a_gnt}, 32'd0);
    chk({tag, "_b_gnt"}, {31'd0, b_gnt}, 32'd0);
    chk({tag, "_a_done"}, {31'd0, a_done}, 32'd0);
    chk({tag, "_b_done"}, {31'd0, b_done}, 32'd0);
    chk({tag, "_mem_en"}, {31'd0, mem_en}, 32'd0);
    chk({tag, "_mem_we"}, {31'd0, mem_we}, 32'd0);
    chk({tag, "_mem_addr"}, {28'd0, mem_addr}, 32'd0);
    chk({tag, "_mem_wdata"}, {24'd0, mem_wdata}, 32'd0);
    chk({tag, "_a_rdata"}, {24'd0, a_rdata}, 32'd0);
    chk({tag, "_b_rdata"}, {24'd0, b_rdata}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    prev = '{g0: 2'd0, g1: 2'd0, we: 1'b0, addr: 4'h0, rd: 1'b0, rdata: 8'h00};
    rst = 1'b1;
    a_req = 0; a_we = 0; a_lock = 0; a_addr = '0; a_wdata = '0;
    b_req = 0; b_we = 0; b_lock = 0; b_addr = '0; b_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("rst");
    rst = 1'b0;

    // A write 3 <= 5A, then A read 3
    cyc(1, 1, 0, 4'h3, 8'h5A, 0, 0, 4'h0, 8'h00, 2'd1, 2'd1, 8'h00);
    cyc(1, 0, 0, 4'h3, 8'h00, 0, 0, 4'h0, 8'h00, 2'd1, 2'd1, 8'h5A);
    idle();
    idle();

    // B write F <= C3, B read F alone; A rdata must stay 5A
    cyc(0, 0, 0, 4'h0, 8'h00, 1, 1, 4'hF, 8'hC3, 2'd2, 2'd2, 8'h00);
    idle();
    cyc(0, 0, 0, 4'h0, 8'h00, 1, 0, 4'hF, 8'h00, 2'd2, 2'd2, 8'hC3);
    idle();
    chk("a_rdata_held", {24'd0, a_rdata}, 32'h5A);
    idle();

    // Both requesting: round-robin alternates, fixed priority keeps A
    for (int i = 0; i < 6; i++)
      cyc(1, 1, 0, 4'h1, 8'h11, 1, 1, 4'h2, 8'h22,
          (i % 2 == 0) ? 2'd1 : 2'd2, 2'd1, 8'h00);
    cyc(0, 0, 0, 4'h0, 8'h00, 1, 1, 4'h2, 8'h22, 2'd2, 2'd2, 8'h00);
    idle();
    chk("tb_mem1", {24'd0, tb_mem[1]}, 32'h11);
    chk("tb_mem2", {24'd0, tb_mem[2]}, 32'h22);

    // A locked burst vs B: A x5, then B, then A again
    for (int i = 0; i < 8; i++)
      cyc(1, 1, 1, 4'h4, 8'h44, 1, 1, 4'h5, 8'h55,
          (i == 5) ? 2'd2 : 2'd1, (i == 5) ? 2'd2 : 2'd1, 8'h00);
    cyc(0, 0, 1, 4'h0, 8'h00, 1, 1, 4'h5, 8'h55, 2'd2, 2'd2, 8'h00);
    idle();

    // Async reset in the middle of an A write to address 3
    cyc(1, 1, 0, 4'h3, 8'hEE, 0, 0, 4'h0, 8'h00, 2'd1, 2'd1, 8'h00);
    a_req = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("async_mem_en", {31'd0, mem_en}, 32'd0);
    chk("async_mem_we", {31'd0, mem_we}, 32'd0);
    chk("async_a_gnt", {31'd0, a_gnt}, 32'd0);
    @(posedge clk); #1;
    chk("write_lost", {24'd0, tb_mem[3]}, 32'h5A);
    chk_reset_outputs("rst2");
    rst = 1'b0;
    prev = '{g0: 2'd0, g1: 2'd0, we: 1'b0, addr: 4'h0, rd: 1'b0, rdata: 8'h00};
    cyc(1, 0, 0, 4'h3, 8'h00, 0, 0, 4'h0, 8'h00, 2'd1, 2'd1, 8'h5A);
    idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
